// File: rtl/wbs_wide_mem_bridge.sv
// -----------------------------------------------------------------------------
// wbs_wide_mem_bridge
//
// Wishbone slave that maps one address window onto NUM_BANKS single-port SRAM
// banks of MEM_WIDTH-bit words. Each wide word is exposed as BEATS consecutive
// 32-bit Wishbone words. Writes are gathered beat by beat and committed to the
// bank in one SRAM cycle when the last beat arrives. Reads fetch the whole wide
// word once and keep it in a one-entry cache, so the remaining beats of that
// word are served without touching the SRAM again.
//
// Address layout (word address): [beat | bank | row | zero bits | window bits]
//
// Ports
//   wb_clk_i, rst_n        clock, asynchronous active-low reset
//   wbs_*                  Wishbone slave (cyc/stb/we/sel/adr/dat in, ack/dat out)
//   access_en              high allows SRAM traffic; low acks with data 0
//   clr_err                clears the sticky error flag
//   err_o                  sticky protocol/range error
//   mem_csb                per-bank chip select, active low
//   mem_web                write enable, active low (shared by all banks)
//   mem_addr, mem_wdata    row address and write word (shared by all banks)
//   mem_rdata              per-bank read words, bank b at [b*MEM_WIDTH +: MEM_WIDTH]
// -----------------------------------------------------------------------------
module wbs_wide_mem_bridge #(
    parameter int          MEM_WIDTH  = 64,
    parameter int          MEM_DEPTH  = 64,
    parameter int          NUM_BANKS  = 8,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h3200_0000,
    parameter logic [31:0] ADDR_MASK  = 32'hFF00_0000,
    localparam int         ROW_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                           wb_clk_i,
    input  logic                           rst_n,
    input  logic                           wbs_stb_i,
    input  logic                           wbs_cyc_i,
    input  logic                           wbs_we_i,
    input  logic [3:0]                     wbs_sel_i,
    input  logic [31:0]                    wbs_adr_i,
    input  logic [31:0]                    wbs_dat_i,
    output logic                           wbs_ack_o,
    output logic [31:0]                    wbs_dat_o,
    input  logic                           access_en,
    input  logic                           clr_err,
    output logic                           err_o,
    output logic [NUM_BANKS-1:0]           mem_csb,
    output logic                           mem_web,
    output logic [ROW_W-1:0]               mem_addr,
    output logic [MEM_WIDTH-1:0]           mem_wdata,
    input  logic [NUM_BANKS*MEM_WIDTH-1:0] mem_rdata
);

    localparam int          BEATS    = (MEM_WIDTH + 31) / 32;
    localparam int          BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int          BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int          BUF_W    = BEATS * 32;
    localparam int          BYTES    = BEATS * 4;
    localparam int          LOW_W    = BEAT_W + BANK_W + ROW_W;
    localparam logic [31:0] LOW_MASK = (LOW_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LOW_W) - 32'd1);
    localparam logic [31:0] BEATS_U  = 32'(BEATS);
    localparam logic [31:0] DEPTH_U  = 32'(MEM_DEPTH);
    localparam logic [31:0] BANKS_U  = 32'(NUM_BANKS);
    localparam logic [1:0]  LAT_LAST = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMMIT  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    // Merge one 32-bit beat into the gather buffer under the byte enables.
    function automatic logic [BUF_W-1:0] merge_data(input logic [BUF_W-1:0] base,
                                                    input logic [BEAT_W-1:0] beat,
                                                    input logic [31:0] wdat,
                                                    input logic [3:0] sel);
        logic [BUF_W-1:0] res;
        res = base;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[32*int'(beat) + 8*i +: 8] = wdat[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Record which bytes of the gather buffer have been written.
    function automatic logic [BYTES-1:0] merge_mask(input logic [BYTES-1:0] base,
                                                    input logic [BEAT_W-1:0] beat,
                                                    input logic [3:0] sel);
        logic [BYTES-1:0] res;
        res = base;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[4*int'(beat) + i] = 1'b1;
            end
        end
        return res;
    endfunction

    // Zero every byte the gather never wrote so stale buffer content never reaches the SRAM.
    function automatic logic [BUF_W-1:0] apply_mask(input logic [BUF_W-1:0] data,
                                                    input logic [BYTES-1:0] mask);
        logic [BUF_W-1:0] res;
        for (int j = 0; j < BYTES; j++) begin
            res[8*j +: 8] = mask[j] ? data[8*j +: 8] : 8'h00;
        end
        return res;
    endfunction

    // Registered state
    state_t                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_o_q, dat_o_d;
    logic                   err_q, err_d;
    logic [NUM_BANKS-1:0]   csb_q, csb_d;
    logic                   web_q, web_d;
    logic [ROW_W-1:0]       addr_q, addr_d;
    logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]             lat_cnt_q, lat_cnt_d;
    logic                   g_valid_q, g_valid_d;
    logic [BANK_W-1:0]      g_bank_q, g_bank_d;
    logic [ROW_W-1:0]       g_row_q, g_row_d;
    logic [BUF_W-1:0]       g_data_q, g_data_d;
    logic [BYTES-1:0]       g_mask_q, g_mask_d;
    logic                   c_valid_q, c_valid_d;
    logic [BANK_W-1:0]      c_bank_q, c_bank_d;
    logic [ROW_W-1:0]       c_row_q, c_row_d;
    logic [BUF_W-1:0]       c_data_q, c_data_d;
    logic [BANK_W-1:0]      rd_bank_q, rd_bank_d;
    logic [ROW_W-1:0]       rd_row_q, rd_row_d;
    logic [BEAT_W-1:0]      rd_beat_q, rd_beat_d;

    // Decode signals
    logic                   req_s;
    logic [BEAT_W-1:0]      req_beat_s;
    logic [BANK_W-1:0]      req_bank_s;
    logic [ROW_W-1:0]       req_row_s;
    logic                   range_err_s;
    logic                   gather_hit_s;
    logic                   cache_hit_s;
    logic                   beat_last_s;
    logic                   wr_ok_s;
    logic                   go_commit_s;
    logic                   go_rdwait_s;
    logic                   set_err_s;
    logic                   rd_done_s;
    logic [BUF_W-1:0]       wr_data_s;
    logic [BYTES-1:0]       wr_mask_s;
    logic [BUF_W-1:0]       commit_buf_s;
    logic [BUF_W-1:0]       rd_buf_s;

    // Request decode: window match, field extraction and classification.
    always_comb begin
        req_s        = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR)
                       & ~ack_q & (state_q == ST_IDLE);
        req_beat_s   = wbs_adr_i[BEAT_W-1:0];
        req_bank_s   = wbs_adr_i[BEAT_W +: BANK_W];
        req_row_s    = wbs_adr_i[BEAT_W+BANK_W +: ROW_W];
        range_err_s  = ((wbs_adr_i & ~ADDR_MASK & ~LOW_MASK) != 32'd0)
                       | (32'(req_beat_s) >= BEATS_U)
                       | (32'(req_bank_s) >= BANKS_U)
                       | (32'(req_row_s) >= DEPTH_U);
        gather_hit_s = g_valid_q & (g_bank_q == req_bank_s) & (g_row_q == req_row_s);
        cache_hit_s  = c_valid_q & (c_bank_q == req_bank_s) & (c_row_q == req_row_s);
        beat_last_s  = (32'(req_beat_s) == (BEATS_U - 32'd1));
        // Beat 0 always (re)opens a gather; later beats must continue the open one.
        wr_ok_s      = (req_beat_s == {BEAT_W{1'b0}}) | gather_hit_s;
        go_commit_s  = access_en & ~range_err_s & wbs_we_i & wr_ok_s & beat_last_s;
        go_rdwait_s  = access_en & ~range_err_s & ~wbs_we_i & ~cache_hit_s;
        set_err_s    = req_s & access_en & (range_err_s | (wbs_we_i & ~wr_ok_s));
        rd_done_s    = (lat_cnt_q == LAT_LAST);
        wr_data_s    = merge_data(g_data_q, req_beat_s, wbs_dat_i, wbs_sel_i);
        wr_mask_s    = merge_mask((req_beat_s == {BEAT_W{1'b0}}) ? {BYTES{1'b0}} : g_mask_q,
                                  req_beat_s, wbs_sel_i);
        commit_buf_s = apply_mask(wr_data_s, wr_mask_s);
        // Bits of the last beat above MEM_WIDTH read back as zero.
        rd_buf_s                  = {BUF_W{1'b0}};
        rd_buf_s[MEM_WIDTH-1:0]   = mem_rdata[int'(rd_bank_q)*MEM_WIDTH +: MEM_WIDTH];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    if (go_commit_s) begin
                        state_d = ST_COMMIT;
                    end else if (go_rdwait_s) begin
                        state_d = ST_RD_WAIT;
                    end else begin
                        state_d = ST_ACK;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT:  state_d = ST_ACK;
            ST_RD_WAIT: begin
                if (rd_done_s) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_ACK:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; every output is registered from these.
    always_comb begin
        ack_d     = 1'b0;
        dat_o_d   = 32'd0;
        err_d     = set_err_s | (err_q & ~clr_err);
        csb_d     = {NUM_BANKS{1'b1}};
        web_d     = 1'b1;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_cnt_d = lat_cnt_q;
        g_valid_d = g_valid_q;
        g_bank_d  = g_bank_q;
        g_row_d   = g_row_q;
        g_data_d  = g_data_q;
        g_mask_d  = g_mask_q;
        c_valid_d = c_valid_q;
        c_bank_d  = c_bank_q;
        c_row_d   = c_row_q;
        c_data_d  = c_data_q;
        rd_bank_d = rd_bank_q;
        rd_row_d  = rd_row_q;
        rd_beat_d = rd_beat_q;
        case (state_q)
            ST_IDLE: begin
                if (!req_s) begin
                    ack_d = 1'b0;
                end else if (!access_en || range_err_s) begin
                    ack_d = 1'b1;
                end else if (wbs_we_i) begin
                    if (!wr_ok_s) begin
                        // Beat does not continue the open gather: dropped.
                        ack_d = 1'b1;
                    end else if (beat_last_s) begin
                        csb_d[req_bank_s] = 1'b0;
                        web_d             = 1'b0;
                        addr_d            = req_row_s;
                        wdata_d           = commit_buf_s[MEM_WIDTH-1:0];
                        g_valid_d         = 1'b0;
                        if (cache_hit_s) begin
                            c_valid_d = 1'b0;
                        end else begin
                            c_valid_d = c_valid_q;
                        end
                    end else begin
                        g_valid_d = 1'b1;
                        g_bank_d  = req_bank_s;
                        g_row_d   = req_row_s;
                        g_data_d  = wr_data_s;
                        g_mask_d  = wr_mask_s;
                        ack_d     = 1'b1;
                    end
                end else if (cache_hit_s) begin
                    ack_d   = 1'b1;
                    dat_o_d = c_data_q[32*int'(req_beat_s) +: 32];
                end else begin
                    csb_d[req_bank_s] = 1'b0;
                    web_d             = 1'b1;
                    addr_d            = req_row_s;
                    rd_bank_d         = req_bank_s;
                    rd_row_d          = req_row_s;
                    rd_beat_d         = req_beat_s;
                    lat_cnt_d         = 2'd0;
                end
            end
            ST_COMMIT: begin
                ack_d = 1'b1;
            end
            ST_RD_WAIT: begin
                // Chip select was low only for the first RD_WAIT cycle; count edges to the capture.
                if (rd_done_s) begin
                    ack_d     = 1'b1;
                    dat_o_d   = rd_buf_s[32*int'(rd_beat_q) +: 32];
                    c_valid_d = 1'b1;
                    c_bank_d  = rd_bank_q;
                    c_row_d   = rd_row_q;
                    c_data_d  = rd_buf_s;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_ACK: begin
                ack_d = 1'b0;
            end
            default: begin
                ack_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            dat_o_q   <= 32'd0;
            err_q     <= 1'b0;
            csb_q     <= {NUM_BANKS{1'b1}};
            web_q     <= 1'b1;
            addr_q    <= {ROW_W{1'b0}};
            wdata_q   <= {MEM_WIDTH{1'b0}};
            lat_cnt_q <= 2'd0;
            g_valid_q <= 1'b0;
            g_bank_q  <= {BANK_W{1'b0}};
            g_row_q   <= {ROW_W{1'b0}};
            g_data_q  <= {BUF_W{1'b0}};
            g_mask_q  <= {BYTES{1'b0}};
            c_valid_q <= 1'b0;
            c_bank_q  <= {BANK_W{1'b0}};
            c_row_q   <= {ROW_W{1'b0}};
            c_data_q  <= {BUF_W{1'b0}};
            rd_bank_q <= {BANK_W{1'b0}};
            rd_row_q  <= {ROW_W{1'b0}};
            rd_beat_q <= {BEAT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dat_o_q   <= dat_o_d;
            err_q     <= err_d;
            csb_q     <= csb_d;
            web_q     <= web_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_cnt_q <= lat_cnt_d;
            g_valid_q <= g_valid_d;
            g_bank_q  <= g_bank_d;
            g_row_q   <= g_row_d;
            g_data_q  <= g_data_d;
            g_mask_q  <= g_mask_d;
            c_valid_q <= c_valid_d;
            c_bank_q  <= c_bank_d;
            c_row_q   <= c_row_d;
            c_data_q  <= c_data_d;
            rd_bank_q <= rd_bank_d;
            rd_row_q  <= rd_row_d;
            rd_beat_q <= rd_beat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign err_o     = err_q;
    assign mem_csb   = csb_q;
    assign mem_web   = web_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_wbs_wide_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_wbs_wide_mem_bridge
//
// Directed bench for wbs_wide_mem_bridge. Instance A uses the default
// parameters (64-bit words, 8 banks, read latency 1); instance B uses a 55-bit
// word, a single bank and read latency 2. The SRAM read data is held constant
// per bank by the bench. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_wbs_wide_mem_bridge;

    logic         clk;
    logic         rst_n;

    // Instance A (defaults)
    logic         a_stb, a_cyc, a_we;
    logic [3:0]   a_sel;
    logic [31:0]  a_adr, a_dat;
    logic         a_ack;
    logic [31:0]  a_dato;
    logic         a_en, a_clr, a_err;
    logic [7:0]   a_csb;
    logic         a_web;
    logic [5:0]   a_addr;
    logic [63:0]  a_wdata;
    logic [511:0] a_rdata;

    // Instance B (55-bit, one bank, latency 2)
    logic         b_stb, b_cyc, b_we;
    logic [3:0]   b_sel;
    logic [31:0]  b_adr, b_dat;
    logic         b_ack;
    logic [31:0]  b_dato;
    logic         b_en, b_clr, b_err;
    logic [0:0]   b_csb;
    logic         b_web;
    logic [5:0]   b_addr;
    logic [54:0]  b_wdata;
    logic [54:0]  b_rdata;

    int n_asserts = 0;
    int n_fail    = 0;

    wbs_wide_mem_bridge u_a (
        .wb_clk_i  (clk),
        .rst_n     (rst_n),
        .wbs_stb_i (a_stb),
        .wbs_cyc_i (a_cyc),
        .wbs_we_i  (a_we),
        .wbs_sel_i (a_sel),
        .wbs_adr_i (a_adr),
        .wbs_dat_i (a_dat),
        .wbs_ack_o (a_ack),
        .wbs_dat_o (a_dato),
        .access_en (a_en),
        .clr_err   (a_clr),
        .err_o     (a_err),
        .mem_csb   (a_csb),
        .mem_web   (a_web),
        .mem_addr  (a_addr),
        .mem_wdata (a_wdata),
        .mem_rdata (a_rdata)
    );

    wbs_wide_mem_bridge #(
        .MEM_WIDTH  (55),
        .NUM_BANKS  (1),
        .RD_LATENCY (2)
    ) u_b (
        .wb_clk_i  (clk),
        .rst_n     (rst_n),
        .wbs_stb_i (b_stb),
        .wbs_cyc_i (b_cyc),
        .wbs_we_i  (b_we),
        .wbs_sel_i (b_sel),
        .wbs_adr_i (b_adr),
        .wbs_dat_i (b_dat),
        .wbs_ack_o (b_ack),
        .wbs_dat_o (b_dato),
        .access_en (b_en),
        .clr_err   (b_clr),
        .err_o     (b_err),
        .mem_csb   (b_csb),
        .mem_web   (b_web),
        .mem_addr  (b_addr),
        .mem_wdata (b_wdata),
        .mem_rdata (b_rdata)
    );

    // 10 time-unit clock, rising edges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer on instance A (which=0) or B (which=1), started at a
    // falling edge. lat = number of rising edges from the sampling edge until ack
    // is seen (1 = ack right after the sampling edge), 0 if no ack within 8.
    task automatic xfer(input int which, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output int lat, output logic [31:0] rdat, output int csb_cnt,
                        output logic [7:0] csb_v, output logic web_v,
                        output logic [5:0] addr_v, output logic [63:0] wdata_v);
        logic [7:0] cur_csb;
        logic       cur_ack;
        lat = 0; rdat = 32'hXXXX_XXXX; csb_cnt = 0;
        csb_v = 8'hFF; web_v = 1'b1; addr_v = 6'd0; wdata_v = 64'd0;
        if (which == 0) begin
            a_we = we; a_adr = adr; a_dat = dat; a_sel = sel; a_cyc = 1'b1; a_stb = 1'b1;
        end else begin
            b_we = we; b_adr = adr; b_dat = dat; b_sel = sel; b_cyc = 1'b1; b_stb = 1'b1;
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            cur_csb = (which == 0) ? a_csb : {7'h7F, b_csb};
            cur_ack = (which == 0) ? a_ack : b_ack;
            if (cur_csb != 8'hFF) begin
                csb_cnt++;
                csb_v   = cur_csb;
                web_v   = (which == 0) ? a_web : b_web;
                addr_v  = (which == 0) ? a_addr : b_addr;
                wdata_v = (which == 0) ? a_wdata : {9'd0, b_wdata};
            end
            if (cur_ack) begin
                lat  = k;
                rdat = (which == 0) ? a_dato : b_dato;
                break;
            end
        end
        @(negedge clk);
        a_cyc = 1'b0; a_stb = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr(input int which);
        if (which == 0) a_clr = 1'b1; else b_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0; b_clr = 1'b0;
    endtask

    initial begin
        int          lat, cc;
        logic [31:0] rd;
        logic [7:0]  cv;
        logic        wv;
        logic [5:0]  av;
        logic [63:0] wd;

        rst_n = 1'b0;
        a_stb = 1'b0; a_cyc = 1'b0; a_we = 1'b0; a_sel = 4'h0; a_adr = 32'd0; a_dat = 32'd0;
        a_en = 1'b1; a_clr = 1'b0;
        b_stb = 1'b0; b_cyc = 1'b0; b_we = 1'b0; b_sel = 4'h0; b_adr = 32'd0; b_dat = 32'd0;
        b_en = 1'b1; b_clr = 1'b0;
        a_rdata = 512'd0;
        a_rdata[7*64 +: 64] = 64'h1100_1010_DEAD_BEEF;
        a_rdata[3*64 +: 64] = 64'h0123_4567_89AB_CDEF;
        a_rdata[0*64 +: 64] = 64'hCAFE_F00D_1234_5678;
        b_rdata = 55'h00_1010_DEAD_BEEF;

        repeat (3) @(negedge clk);
        check("rst_ack",   {63'd0, a_ack},   64'd0);
        check("rst_dat",   {32'd0, a_dato},  64'd0);
        check("rst_err",   {63'd0, a_err},   64'd0);
        check("rst_csb",   {56'd0, a_csb},   64'hFF);
        check("rst_web",   {63'd0, a_web},   64'd1);
        check("rst_addr",  {58'd0, a_addr},  64'd0);
        check("rst_wdata", a_wdata,          64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full write of bank 1 row 3
        xfer(0, 1'b1, 32'h3200_0032, 32'h7654_3210, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("w0_lat", 64'(lat), 64'd1);
        check("w0_csb_cnt", 64'(cc), 64'd0);
        xfer(0, 1'b1, 32'h3200_0033, 32'hFEDC_BA98, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("w1_lat", 64'(lat), 64'd2);
        check("w1_csb_cnt", 64'(cc), 64'd1);
        check("w1_csb", {56'd0, cv}, 64'hFD);
        check("w1_web", {63'd0, wv}, 64'd0);
        check("w1_addr", {58'd0, av}, 64'd3);
        check("w1_wdata", wd, 64'hFEDC_BA98_7654_3210);
        check("w1_err", {63'd0, a_err}, 64'd0);

        // Partial byte enables: unwritten bytes commit as zero
        xfer(0, 1'b1, 32'h3200_0044, 32'hAABB_CCDD, 4'b0011, lat, rd, cc, cv, wv, av, wd);
        check("pw0_lat", 64'(lat), 64'd1);
        xfer(0, 1'b1, 32'h3200_0045, 32'h1122_3344, 4'b1000, lat, rd, cc, cv, wv, av, wd);
        check("pw1_lat", 64'(lat), 64'd2);
        check("pw1_csb", {56'd0, cv}, 64'hFB);
        check("pw1_addr", {58'd0, av}, 64'd4);
        check("pw1_wdata", wd, 64'h1100_0000_0000_CCDD);

        // Read miss then hit, bank 7 row 0
        xfer(0, 1'b0, 32'h3200_000E, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("rmiss_lat", 64'(lat), 64'd2);
        check("rmiss_csb_cnt", 64'(cc), 64'd1);
        check("rmiss_csb", {56'd0, cv}, 64'h7F);
        check("rmiss_web", {63'd0, wv}, 64'd1);
        check("rmiss_addr", {58'd0, av}, 64'd0);
        check("rmiss_dat", {32'd0, rd}, 64'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h3200_000F, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("rhit_lat", 64'(lat), 64'd1);
        check("rhit_csb_cnt", 64'(cc), 64'd0);
        check("rhit_dat", {32'd0, rd}, 64'h1100_1010);

        // A read between gather beats leaves the gather intact
        xfer(0, 1'b1, 32'h3200_0062, 32'h0A0B_0C0D, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("gw0_lat", 64'(lat), 64'd1);
        xfer(0, 1'b0, 32'h3200_000F, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("grd_lat", 64'(lat), 64'd1);
        check("grd_dat", {32'd0, rd}, 64'h1100_1010);
        xfer(0, 1'b1, 32'h3200_0063, 32'h0102_0304, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("gw1_lat", 64'(lat), 64'd2);
        check("gw1_addr", {58'd0, av}, 64'd6);
        check("gw1_wdata", wd, 64'h0102_0304_0A0B_0C0D);

        // Commit to the cached row invalidates the cache
        xfer(0, 1'b1, 32'h3200_000E, 32'h0000_0000, 4'hF, lat, rd, cc, cv, wv, av, wd);
        xfer(0, 1'b1, 32'h3200_000F, 32'h0000_0000, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("inv_commit_csb", {56'd0, cv}, 64'h7F);
        xfer(0, 1'b0, 32'h3200_000F, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("inv_rd_csb_cnt", 64'(cc), 64'd1);
        check("inv_rd_lat", 64'(lat), 64'd2);

        // Gather mismatch: beat 1 to a different row is dropped with error
        xfer(0, 1'b1, 32'h3200_0020, 32'h1111_1111, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("mm_w0_err", {63'd0, a_err}, 64'd0);
        xfer(0, 1'b1, 32'h3200_0051, 32'h2222_2222, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("mm_lat", 64'(lat), 64'd1);
        check("mm_csb_cnt", 64'(cc), 64'd0);
        check("mm_err", {63'd0, a_err}, 64'd1);
        pulse_clr(0);
        check("mm_clr", {63'd0, a_err}, 64'd0);

        // Nonzero bit between row field and window: error, data 0
        xfer(0, 1'b0, 32'h3200_0400, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("hi_lat", 64'(lat), 64'd1);
        check("hi_dat", {32'd0, rd}, 64'd0);
        check("hi_csb_cnt", 64'(cc), 64'd0);
        check("hi_err", {63'd0, a_err}, 64'd1);
        pulse_clr(0);

        // Outside the window: no ack at all
        xfer(0, 1'b0, 32'h3300_0000, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("unsel_lat", 64'(lat), 64'd0);
        check("unsel_csb_cnt", 64'(cc), 64'd0);

        // access_en low: ack with data 0, no SRAM access, no error
        a_en = 1'b0;
        xfer(0, 1'b0, 32'h3200_0000, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("dis_lat", 64'(lat), 64'd1);
        check("dis_dat", {32'd0, rd}, 64'd0);
        check("dis_csb_cnt", 64'(cc), 64'd0);
        check("dis_err", {63'd0, a_err}, 64'd0);
        a_en = 1'b1;

        // Instance B: 55-bit words, read latency 2
        xfer(1, 1'b0, 32'h3200_0001, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("b_rmiss_lat", 64'(lat), 64'd3);
        check("b_rmiss_csb_cnt", 64'(cc), 64'd1);
        check("b_rmiss_dat", {32'd0, rd}, 64'h0000_1010);
        xfer(1, 1'b0, 32'h3200_0000, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("b_rhit_lat", 64'(lat), 64'd1);
        check("b_rhit_dat", {32'd0, rd}, 64'hDEAD_BEEF);
        xfer(1, 1'b1, 32'h3200_0000, 32'hFFFF_FFFF, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("b_w0_lat", 64'(lat), 64'd1);
        xfer(1, 1'b1, 32'h3200_0001, 32'hFFFF_FFFF, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("b_w1_lat", 64'(lat), 64'd2);
        check("b_w1_csb", {56'd0, cv}, 64'hFE);
        check("b_w1_wdata", wd, 64'h007F_FFFF_FFFF_FFFF);
        xfer(1, 1'b0, 32'h3200_0002, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("b_bank_lat", 64'(lat), 64'd1);
        check("b_bank_dat", {32'd0, rd}, 64'd0);
        check("b_bank_err", {63'd0, b_err}, 64'd1);

        // Reset during RD_WAIT abandons the read and invalidates the cache
        xfer(0, 1'b0, 32'h3200_0016, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("c3_miss_dat", {32'd0, rd}, 64'h89AB_CDEF);
        xfer(0, 1'b0, 32'h3200_0017, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("c3_hit_csb_cnt", 64'(cc), 64'd0);
        check("c3_hit_dat", {32'd0, rd}, 64'h0123_4567);
        a_we = 1'b0; a_adr = 32'h3200_0026; a_sel = 4'hF; a_cyc = 1'b1; a_stb = 1'b1;
        @(posedge clk);
        #1;
        check("rw_csb", {56'd0, a_csb}, 64'hF7);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_rst_csb", {56'd0, a_csb}, 64'hFF);
        check("rw_rst_ack", {63'd0, a_ack}, 64'd0);
        a_cyc = 1'b0; a_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(0, 1'b0, 32'h3200_0016, 32'd0, 4'hF, lat, rd, cc, cv, wv, av, wd);
        check("post_rst_csb_cnt", 64'(cc), 64'd1);
        check("post_rst_lat", 64'(lat), 64'd2);
        check("post_rst_dat", {32'd0, rd}, 64'h89AB_CDEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
